// File: rtl/save_counter.sv
// save_counter: snapshot-and-clear register for the ADPLL counter path
// On each rising edge of trigger_i, captures counter_val_i into a holding
// register and emits a one-cycle clear strobe to the upstream counter.
//   fpga_clk_i          in   system clock (rising edge)
//   reset_i             in   asynchronous active-low reset
//   trigger_i           in   save request, rising-edge sensitive
//   counter_val_i       in   live signed counter value
//   counter_val_saved_o out  last captured value (registered)
//   counter_cleared_o   out  one-cycle clear strobe (registered)
// Option: define SAVE_COUNTER_TRIG_SYNC_EN to pass trigger_i through a
// 2-flop synchronizer (adds 2 cycles of latency) for asynchronous triggers.
module save_counter #(
    parameter int WIDTH = 20
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    trigger_i,
    input  logic signed [WIDTH-1:0] counter_val_i,
    output logic signed [WIDTH-1:0] counter_val_saved_o,
    output logic                    counter_cleared_o
);
    logic trig_s;
    logic trig_q;
    logic save;
`ifdef SAVE_COUNTER_TRIG_SYNC_EN
    logic [1:0] sync_q;
    // Synchronizer resets high so a trigger already high at reset release
    // cannot look like a rising edge.
    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], trigger_i};
    end
    assign trig_s = sync_q[1];
`else
    assign trig_s = trigger_i;
`endif
    assign save = trig_s && !trig_q;
    // trig_q resets high so a trigger held through reset release does not fire.
    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            trig_q              <= 1'b1;
            counter_val_saved_o <= '0;
            counter_cleared_o   <= 1'b0;
        end else begin
            trig_q            <= trig_s;
            counter_cleared_o <= save;
            if (save) counter_val_saved_o <= counter_val_i;
        end
    end
endmodule

// File: tb/tb_save_counter.sv
// tb_save_counter: randomized self-checking bench for save_counter
module tb_save_counter;
    localparam int W = 20;
`ifdef SAVE_COUNTER_TRIG_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          trigger_i = 1'b0;
    logic [W-1:0]  counter_val_i = '0;
    logic [W-1:0]  counter_val_saved_o;
    logic          counter_cleared_o;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            strobes = 0;
    // Reference model: history of sampled trigger levels; a save happens
    // where the (possibly delayed) sampled trigger goes 0 -> 1.
    logic          hist[$];
    logic [W-1:0]  m_saved;
    logic          m_clr;

    save_counter #(.WIDTH(W)) dut (
        .fpga_clk_i          (clk),
        .reset_i             (reset_i),
        .trigger_i           (trigger_i),
        .counter_val_i       (counter_val_i),
        .counter_val_saved_o (counter_val_saved_o),
        .counter_cleared_o   (counter_cleared_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        hist.delete();
        repeat (LAT + 1) hist.push_back(1'b1);
        m_saved = '0;
        m_clr   = 1'b0;
    endtask

    task automatic m_edge(input logic t, input logic [W-1:0] v);
        logic cur, prev;
        hist.push_back(t);
        cur  = hist[hist.size()-1-LAT];
        prev = hist[hist.size()-2-LAT];
        m_clr = cur && !prev;
        if (m_clr) m_saved = v;
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_saved"}, 32'(counter_val_saved_o), 32'(m_saved));
        chk({tag, "_clr"}, 32'(counter_cleared_o), 32'(m_clr));
    endtask

    // Drive one cycle's inputs, let the edge happen, then check 1 ns later.
    task automatic cyc(input logic t, input logic [W-1:0] v, input string tag);
        trigger_i     = t;
        counter_val_i = v;
        @(posedge clk);
        m_edge(t, v);
        #1;
        check_out(tag);
        strobes += int'(counter_cleared_o);
    endtask

    // Assert reset asynchronously, verify immediate effect, release away from edges.
    task automatic do_reset(input string tag);
        reset_i = 1'b0;
        #1;
        m_reset();
        check_out({tag, "_async"});
        repeat (2) @(posedge clk);
        #1;
        check_out({tag, "_held"});
        @(negedge clk);
        reset_i = 1'b1;
    endtask

    initial begin
        m_reset();
        counter_val_i = 20'h0000A;
        trigger_i     = 1'b0;
        do_reset("reset");

        cyc(0, 20'h0000A, "pre");
        cyc(1, 20'h0000A, "pulse");
        repeat (4) cyc(0, 20'h0000A, "pulse_hold");

        strobes = 0;
        for (int i = 1; i <= 5; i++) cyc(1, W'(i), "held");
        repeat (4) cyc(0, 20'h00000, "held_after");
        chk("held_strobes", 32'(strobes), 32'd1);

        cyc(1, 20'hFFFF6, "neg");
        repeat (3) cyc(0, 20'hFFFF6, "neg_hold");
        cyc(1, 20'h80000, "min");
        repeat (3) cyc(0, 20'h80000, "min_hold");

        strobes = 0;
        cyc(1, 20'd3, "b2b"); cyc(0, 20'd3, "b2b");
        cyc(1, 20'd7, "b2b"); cyc(0, 20'd7, "b2b");
        cyc(1, 20'd9, "b2b"); cyc(0, 20'd9, "b2b");
        repeat (3) cyc(0, 20'd9, "b2b_tail");
        chk("b2b_strobes", 32'(strobes), 32'd3);

        trigger_i = 1'b1;
        do_reset("rst_trig_hi");
        strobes = 0;
        repeat (4) cyc(1, 20'h12345, "trig_hi_release");
        chk("trig_hi_strobes", 32'(strobes), 32'd0);

        cyc(0, 20'h00055, "mid_pre");
        cyc(1, 20'h00055, "mid_go");
        for (int i = 0; i < LAT; i++) cyc(0, 20'h00055, "mid_wait");
        #2;
        do_reset("mid_strobe");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                @(negedge clk);
                #2;
                do_reset("rnd_rst");
            end
            cyc(1'($urandom_range(0, 1)), W'($urandom), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/save_counter.md
# save_counter

Snapshot-and-clear register for the ADPLL counter path. On each rising edge of `trigger_i` it captures the current signed counter value into a holding register and emits a one-cycle clear strobe, so the upstream counter can restart from zero. The held value stays stable for downstream loop-filter and phase logic until the next trigger.

## Interface
Parameters:
- `WIDTH`: default 20; bit width of the signed counter value. Legal range is `WIDTH >= 2`.

Ports:
- `fpga_clk_i`, in, 1 bit: system clock. All state updates on its rising edge.
- `reset_i`, in, 1 bit: asynchronous, active-low reset.
- `trigger_i`, in, 1 bit: save request. Level input; the block acts on its rising edge.
- `counter_val_i`, in, `WIDTH` bits, signed: live counter value to capture.
- `counter_val_saved_o`, out, `WIDTH` bits, signed: last captured counter value. Registered.
- `counter_cleared_o`, out, 1 bit: one-cycle clear strobe to the upstream counter. Registered.

## Operation
- Internal register `trig_q` holds the previous sampled value of the trigger.
- A save event is `trig_s && !trig_q`, where `trig_s` is the trigger as sampled:
  - `trigger_i` directly by default.
  - The synchronizer output when the option in Configuration is compiled in.
- On a save event:
  - `counter_val_saved_o <= counter_val_i`, copied bit-exact with no sign extension, saturation or arithmetic.
  - `counter_cleared_o <= 1`.
- On any cycle without a save event:
  - `counter_val_saved_o` holds its value.
  - `counter_cleared_o <= 0`.
- Trigger held high for N cycles produces exactly one save and one clear strobe. A new save requires `trigger_i` to go low for at least one sampled cycle first.
- Negative values, including the most negative value (-2^(WIDTH-1)), are stored unchanged.
- There are no other states; the block is a pure edge-detect plus capture register.

## Timing
- Reset asserted (`reset_i` = 0) takes effect immediately:
  - `counter_val_saved_o` = 0.
  - `counter_cleared_o` = 0.
  - `trig_q` = 1, and synchronizer flops = 1 when present.
- Because `trig_q` resets to 1, a trigger that is high while reset deasserts does not fire. It must fall and rise again.
- Reset asserted mid-strobe aborts the strobe: `counter_cleared_o` drops to 0 asynchronously and the saved value returns to 0.
- Latency without the synchronizer:
  - `trigger_i` is first sampled high at clock edge k.
  - `counter_val_saved_o` shows the `counter_val_i` value sampled at edge k from edge k on.
  - `counter_cleared_o` is high for the cycle between edges k and k+1.
- Minimum trigger spacing: high 1 cycle, low 1 cycle, giving one save every 2 cycles.
- `counter_val_i` must be stable across the sampling edge; no other input setup requirement beyond the clock.

## Configuration
- `SAVE_COUNTER_TRIG_SYNC_EN`:
  - Defined: `trigger_i` passes through a 2-flop synchronizer (reset to 1) before edge detection. Save and strobe occur 2 cycles later than without it, i.e. at edge k+2. This allows an asynchronous trigger, such as the DCO/reference domain.
  - Undefined: `trigger_i` is used directly and must be synchronous to `fpga_clk_i`.

## Test plan
- Reset check: hold `reset_i` = 0 with `counter_val_i` = 0x0000A and `trigger_i` = 0 → `counter_val_saved_o` = 0, `counter_cleared_o` = 0.
- Single pulse: release reset, `counter_val_i` = 0x0000A, then `trigger_i` high for 1 cycle → `counter_val_saved_o` = 0x0000A (10) from that edge; `counter_cleared_o` high for exactly 1 cycle; value held afterwards.
- Held trigger: `trigger_i` high for 5 cycles while `counter_val_i` changes 1→5 → saved = 1, exactly one strobe.
- Negative and extreme values: triggers with `counter_val_i` = 0xFFFF6 (-10), then 0x80000 → saved values match bit-exact.
- Back-to-back and reset interaction:
  - Alternating trigger 1/0 with values 3, 7, 9 → three strobes, saved value 9.
  - `trigger_i` high during reset release → no strobe.
  - Reset asserted during a strobe → outputs go to 0 immediately.
- With `SAVE_COUNTER_TRIG_SYNC_EN` defined: repeat the single-pulse case → save and strobe occur 2 cycles later, saved value is 0x0000A.
